// File: rtl/sp_ram_banked.sv
// Banked single-port RAM: byte-enabled writes, in-order responses after 1 or 2 cycles,
// and per-bank power management that puts idle banks to sleep and wakes them on demand.

module sp_ram_banked #(
    parameter int RAM_SIZE    = 32768,
    parameter int ADDR_WIDTH  = $clog2(RAM_SIZE),
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_BANKS   = 4,
    parameter int IDLE_CYCLES = 64,
    parameter int WAKE_CYCLES = 2,
    parameter int OUT_REG     = 0
) (
    input  logic                    clk,
    input  logic                    rstn_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic                    we_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic                    rvalid_o,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    input  logic                    bypass_en_i,
    output logic [NUM_BANKS-1:0]    bank_sleep_o
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int BYTE_OFF  = $clog2(BYTES);
    localparam int WORD_W    = ADDR_WIDTH - BYTE_OFF;
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROW_W     = WORD_W - BANK_BITS;
    localparam int DEPTH     = RAM_SIZE / BYTES / NUM_BANKS;
    localparam int IDLE_W    = (IDLE_CYCLES < 2) ? 1 : $clog2(IDLE_CYCLES);
    localparam int WAKE_W    = (WAKE_CYCLES < 2) ? 1 : $clog2(WAKE_CYCLES);

    localparam logic [1:0] ST_ACTIVE = 2'd0;
    localparam logic [1:0] ST_SLEEP  = 2'd1;
    localparam logic [1:0] ST_WAKE   = 2'd2;

    logic [WORD_W-1:0]     word_idx;
    logic [BANK_W-1:0]     bank_sel;
    logic [ROW_W-1:0]      row_sel;
    logic [NUM_BANKS-1:0]  bank_req;
    logic [1:0]            bank_state [NUM_BANKS];
    logic [IDLE_W-1:0]     idle_cnt   [NUM_BANKS];
    logic [WAKE_W-1:0]     wake_cnt   [NUM_BANKS];
    logic [DATA_WIDTH-1:0] mem        [NUM_BANKS][DEPTH];
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_data;

    assign word_idx = addr_i[ADDR_WIDTH-1:BYTE_OFF];

    generate
        if (BYTE_OFF > 0) begin : g_byte_off
            logic addr_unused;
            assign addr_unused = ^addr_i[BYTE_OFF-1:0];
        end

        if (BANK_BITS > 0) begin : g_multi_bank
            assign bank_sel = word_idx[BANK_BITS-1:0];
            assign row_sel  = word_idx[WORD_W-1:BANK_BITS];
        end else begin : g_single_bank
            assign bank_sel = '0;
            assign row_sel  = word_idx;
        end
    endgenerate

    always_comb begin
        bank_req = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_req[b] = req_i && (bank_sel == BANK_W'(b));
        end
    end

    assign gnt_o = req_i && rstn_i && (bank_state[bank_sel] == ST_ACTIVE);

    always_comb begin
        bank_sleep_o = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_sleep_o[b] = (bank_state[b] != ST_ACTIVE);
        end
    end

    // In ACTIVE a request always means a grant, so bank_req doubles as "granted to this bank".
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                bank_state[b] <= ST_ACTIVE;
                idle_cnt[b]   <= '0;
                wake_cnt[b]   <= '0;
            end
        end else begin
            for (int b = 0; b < NUM_BANKS; b++) begin
                case (bank_state[b])
                    ST_ACTIVE: begin
                        if (IDLE_CYCLES == 0 || bypass_en_i || bank_req[b]) begin
                            idle_cnt[b] <= '0;
                        end else if (idle_cnt[b] == IDLE_W'(IDLE_CYCLES - 1)) begin
                            bank_state[b] <= ST_SLEEP;
                            idle_cnt[b]   <= '0;
                        end else begin
                            idle_cnt[b] <= idle_cnt[b] + 1'b1;
                        end
                    end
                    // The wake-triggering cycle counts as the first of the WAKE_CYCLES stalls.
                    ST_SLEEP: begin
                        if (bank_req[b] || bypass_en_i) begin
                            if (WAKE_CYCLES <= 1) begin
                                bank_state[b] <= ST_ACTIVE;
                            end else begin
                                bank_state[b] <= ST_WAKE;
                                wake_cnt[b]   <= WAKE_W'(1);
                            end
                        end
                    end
                    ST_WAKE: begin
                        if (wake_cnt[b] >= WAKE_W'(WAKE_CYCLES - 1)) begin
                            bank_state[b] <= ST_ACTIVE;
                            wake_cnt[b]   <= '0;
                            idle_cnt[b]   <= '0;
                        end else begin
                            wake_cnt[b] <= wake_cnt[b] + 1'b1;
                        end
                    end
                    default: begin
                        bank_state[b] <= ST_ACTIVE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (gnt_o && we_i) begin
            for (int i = 0; i < BYTES; i++) begin
                if (be_i[i]) begin
                    mem[bank_sel][row_sel][i*8 +: 8] <= wdata_i[i*8 +: 8];
                end
            end
        end
    end

    // Read data only moves on reads, so it naturally holds across writes and idle cycles.
    always_ff @(posedge clk) begin
        if (!rstn_i) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= gnt_o;
            if (gnt_o && !we_i) begin
                s1_data <= mem[bank_sel][row_sel];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic                  s1_read;
            logic                  s2_valid;
            logic [DATA_WIDTH-1:0] s2_data;

            always_ff @(posedge clk) begin
                if (!rstn_i) begin
                    s1_read  <= 1'b0;
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s1_read  <= gnt_o && !we_i;
                    s2_valid <= s1_valid;
                    if (s1_valid && s1_read) begin
                        s2_data <= s1_data;
                    end
                end
            end

            assign rvalid_o = s2_valid;
            assign rdata_o  = s2_data;
        end else begin : g_no_out_reg
            assign rvalid_o = s1_valid;
            assign rdata_o  = s1_data;
        end
    endgenerate

endmodule

// File: doc/sp_ram_banked.md
SP_RAM_BANKED -- requirements
Module: sp_ram_banked

Interface
REQ-001 Parameter RAM_SIZE, default 32768, SHALL be the total capacity in bytes.
REQ-002 Parameter ADDR_WIDTH, default $clog2(RAM_SIZE), SHALL be the byte-address width.
REQ-003 Parameter DATA_WIDTH, default 32, SHALL be the word width (multiple of 8).
REQ-004 Parameter NUM_BANKS, default 4, SHALL be the bank count (power of 2, ≥1).
REQ-005 Parameter IDLE_CYCLES, default 64, SHALL be the idle cycles before a bank sleeps; 0 disables sleep.
REQ-006 Parameter WAKE_CYCLES, default 2, SHALL be the sleep-to-active latency in cycles (≥1).
REQ-007 Parameter OUT_REG, default 0, SHALL add one read-data register stage when set to 1.
REQ-008 clk  in  1  sole clock; all logic on its rising edge.
REQ-009 rstn_i  in  1  reset, synchronous, active-low.
REQ-010 req_i  in  1  access request.
REQ-011 gnt_o  out  1  request accepted this cycle.
REQ-012 addr_i  in  ADDR_WIDTH  byte address.
REQ-013 we_i  in  1  1 = write, 0 = read.
REQ-014 be_i  in  DATA_WIDTH/8  byte enables, active-high.
REQ-015 wdata_i  in  DATA_WIDTH  write data.
REQ-016 rvalid_o  out  1  response for an earlier granted request.
REQ-017 rdata_o  out  DATA_WIDTH  read data, valid when rvalid_o=1 for a read.
REQ-018 bypass_en_i  in  1  1 = force all banks active and inhibit sleep.
REQ-019 bank_sleep_o  out  NUM_BANKS  per-bank asleep indication (SLEEP or WAKE).

Function
REQ-020 Word index SHALL be addr_i[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)]; bank = low $clog2(NUM_BANKS) bits of word index; row = remaining bits.
REQ-021 Each bank SHALL hold RAM_SIZE/(DATA_WIDTH/8)/NUM_BANKS words; contents are not reset and are retained in SLEEP.
REQ-022 gnt_o SHALL be combinational: req_i=1 and the addressed bank is ACTIVE.
REQ-023 A granted write SHALL update only the bytes with be_i=1 at the granting edge.
REQ-024 A granted read SHALL return the row's data on rdata_o with rvalid_o=1 exactly 1 cycle after grant (OUT_REG=0) or 2 cycles (OUT_REG=1).
REQ-025 A granted write SHALL produce rvalid_o=1 with the same latency; rdata_o SHALL hold its previous value.
REQ-026 Back-to-back grants SHALL be accepted every cycle; responses are in order, one per grant.
REQ-027 rdata_o SHALL hold its last read value while rvalid_o=0.
REQ-028 Read of a byte written in the previous granted cycle SHALL return the new data (write-then-read, no hazard).
REQ-029 Each bank SHALL run an FSM ACTIVE -> SLEEP -> WAKE -> ACTIVE with an idle counter and a wake counter.
REQ-030 ACTIVE: idle counter clears on any grant to that bank, else increments; at IDLE_CYCLES consecutive idle cycles the bank SHALL enter SLEEP.
REQ-031 A grant in the cycle the counter would reach IDLE_CYCLES SHALL win; bank stays ACTIVE, counter clears.
REQ-032 SLEEP: req_i addressed to the bank, or bypass_en_i=1, SHALL move it to WAKE; gnt_o=0.
REQ-033 WAKE: gnt_o=0 for WAKE_CYCLES cycles, then ACTIVE with idle counter 0; requester holds req_i/addr_i stable until gnt_o.
REQ-034 bypass_en_i=1 SHALL hold ACTIVE banks' idle counters at 0; IDLE_CYCLES=0 SHALL keep all banks ACTIVE permanently.
REQ-035 bank_sleep_o[b] SHALL be 1 in SLEEP and WAKE, 0 in ACTIVE.

Reset
REQ-036 rstn_i=0 at a rising edge SHALL set all banks ACTIVE, clear idle/wake counters, rvalid_o=0, rdata_o=0, bank_sleep_o=0.
REQ-037 gnt_o SHALL be 0 while rstn_i=0; responses in flight at reset SHALL be dropped (no rvalid_o after reset release).
REQ-038 First request after release SHALL be grantable in the first cycle rstn_i=1.

Verification
REQ-039 Write 0xDEADBEEF be=0xF to 0x0010, then read 0x0010 -> gnt_o both cycles, read rvalid_o 1 cycle later with 0xDEADBEEF (2 with OUT_REG=1).
REQ-040 Write 0x11223344 to 0x0020, then write 0xAABBCCDD be=0x5 -> read returns 0x11BB33DD.
REQ-041 IDLE_CYCLES=8, no access to bank 1 for 8 cycles -> bank_sleep_o[1]=1; req to 0x0004 -> gnt_o=0 for WAKE_CYCLES=2 cycles then 1; prior data intact.
REQ-042 Grant to bank 0 on the 8th idle cycle -> bank 0 never sleeps, counter restarts.
REQ-043 All banks asleep, bypass_en_i=1 -> all bank_sleep_o clear after WAKE_CYCLES, none re-sleep while held.
REQ-044 rstn_i=0 the cycle after a granted read -> no rvalid_o, rdata_o=0, bank_sleep_o=0 after the edge.
